// File: rtl/imm_extend_pipe.sv
// Registered immediate extender for the decode stage, wrapped in a 2-entry
// elastic buffer (shift structure, entry 0 is always the head).
module imm_extend_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [1:0]       occupancy_o
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_SEXT  = 2'b00;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_BR    = 2'b11;

    logic [1:0]       r_occ;
    logic [OUT_W-1:0] r_data0;
    logic [OUT_W-1:0] r_data1;

    logic [1:0]       w_occ_nxt;
    logic [OUT_W-1:0] w_data0_nxt;
    logic [OUT_W-1:0] w_data1_nxt;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    // Extension is done on entry so the stored value is already final.
    assign w_sext = {{EXT_W{imm_i[IN_W-1]}}, imm_i};

    always_comb begin
        w_ext = w_sext;
        case (mode_i)
            MODE_SEXT:  w_ext = w_sext;
            MODE_ZEXT:  w_ext = {{EXT_W{1'b0}}, imm_i};
            MODE_UPPER: w_ext = {imm_i, {EXT_W{1'b0}}};
            MODE_BR:    w_ext = w_sext << 2;
            default:    w_ext = w_sext;
        endcase
    end

    // Status is a pure decode of the occupancy register, never of valid_i.
    assign ready_o     = (r_occ != 2'd2);
    assign valid_o     = (r_occ != 2'd0);
    assign data_o      = r_data0;
    assign occupancy_o = r_occ;

    assign w_push = valid_i & ready_o;
    assign w_pop  = valid_o & ready_i;

    always_comb begin
        w_occ_nxt   = r_occ;
        w_data0_nxt = r_data0;
        w_data1_nxt = r_data1;
        if (flush_i) begin
            w_occ_nxt = 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_push) begin
                        w_data0_nxt = w_ext;
                        w_occ_nxt   = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        w_data0_nxt = w_ext;
                    end else if (w_push) begin
                        w_data1_nxt = w_ext;
                        w_occ_nxt   = 2'd2;
                    end else if (w_pop) begin
                        w_occ_nxt = 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        w_data0_nxt = r_data1;
                        w_occ_nxt   = 2'd1;
                    end
                end
                default: w_occ_nxt = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_occ   <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_data0 <= w_data0_nxt;
            r_data1 <= w_data1_nxt;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: vector table for extension modes plus
// hand sequences for backpressure, streaming, flush and asynchronous reset.
module tb_imm_extend_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, ready_i, flush_i;
    logic [15:0] imm_i;
    logic [1:0]  mode_i;
    logic        ready_o, valid_o;
    logic [31:0] data_o;
    logic [1:0]  occupancy_o;

    logic        v12_valid_i;
    logic [11:0] v12_imm_i;
    logic [1:0]  v12_mode_i;
    logic        v12_ready_o, v12_valid_o;
    logic [23:0] v12_data_o;
    logic [1:0]  v12_occ_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .imm_i(imm_i), .mode_i(mode_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .occupancy_o(occupancy_o)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(24)) u_dut12 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(v12_valid_i), .ready_o(v12_ready_o),
        .imm_i(v12_imm_i), .mode_i(v12_mode_i), .flush_i(1'b0), .valid_o(v12_valid_o),
        .ready_i(1'b1), .data_o(v12_data_o), .occupancy_o(v12_occ_o)
    );

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [11:0] imm;
        logic [1:0]  mode;
        logic [23:0] exp;
    } vec12_t;

    vec_t   vecs[6];
    vec12_t vecs12[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance one clock and settle away from the active edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h8004, 2'b00, 32'hFFFF8004};
        vecs[1] = '{16'h8004, 2'b01, 32'h00008004};
        vecs[2] = '{16'h8004, 2'b10, 32'h80040000};
        vecs[3] = '{16'h8004, 2'b11, 32'hFFFE0010};
        vecs[4] = '{16'h7FFF, 2'b00, 32'h00007FFF};
        vecs[5] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
        vecs12[0] = '{12'h800, 2'b00, 24'hFFF800};
        vecs12[1] = '{12'h800, 2'b01, 24'h000800};
        vecs12[2] = '{12'h800, 2'b10, 24'h800000};
        vecs12[3] = '{12'h800, 2'b11, 24'hFFE000};

        rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
        imm_i = '0; mode_i = 2'b00;
        v12_valid_i = 1'b0; v12_imm_i = '0; v12_mode_i = 2'b00;
        #1;
        chk("reset_occ",   32'(occupancy_o), 32'd0);
        chk("reset_valid", 32'(valid_o),     32'd0);
        chk("reset_ready", 32'(ready_o),     32'd1);
        chk("reset_data",  data_o,           32'd0);
        step(); step();
        rst_i = 1'b1;
        step();

        // Mode table: each vector is visible one edge after its push.
        foreach (vecs[i]) begin
            valid_i = 1'b1; imm_i = vecs[i].imm; mode_i = vecs[i].mode;
            step();
            valid_i = 1'b0;
            chk($sformatf("mode_vec%0d_data", i), data_o, vecs[i].exp);
            chk($sformatf("mode_vec%0d_valid", i), 32'(valid_o), 32'd1);
            step();
            chk($sformatf("mode_vec%0d_drain", i), 32'(occupancy_o), 32'd0);
        end
        chk("idle_data_hold", data_o, 32'hFFFFFFFC);

        // Backpressure: two entries held, head stable, then drained in order.
        ready_i = 1'b0; mode_i = 2'b00;
        valid_i = 1'b1; imm_i = 16'h0001; step();
        imm_i = 16'h0002; step();
        valid_i = 1'b0;
        chk("bp_occ2",    32'(occupancy_o), 32'd2);
        chk("bp_ready0",  32'(ready_o),     32'd0);
        chk("bp_head",    data_o,           32'h1);
        step();
        chk("bp_head_hold", data_o,         32'h1);
        ready_i = 1'b1;
        step();
        chk("bp_second",  data_o,           32'h2);
        chk("bp_occ1",    32'(occupancy_o), 32'd1);
        step();
        chk("bp_occ0",    32'(occupancy_o), 32'd0);
        chk("bp_valid0",  32'(valid_o),     32'd0);

        // Streaming push+pop each cycle holds occupancy at 1 with no bubbles.
        for (int k = 0; k < 10; k++) begin
            valid_i = 1'b1; mode_i = 2'b01; imm_i = 16'(16'h0100 + k);
            step();
            chk($sformatf("stream%0d_data", k), data_o, 32'(16'h0100 + k));
            chk($sformatf("stream%0d_occ", k), 32'(occupancy_o), 32'd1);
        end
        valid_i = 1'b0;
        step();
        chk("stream_drain", 32'(occupancy_o), 32'd0);

        // Flush beats a concurrent push; the pushed value must never surface.
        ready_i = 1'b0; mode_i = 2'b00;
        valid_i = 1'b1; imm_i = 16'h0011; step();
        imm_i = 16'h0022; step();
        chk("flush_pre_occ", 32'(occupancy_o), 32'd2);
        ready_i = 1'b1; flush_i = 1'b1; imm_i = 16'h0033;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_occ0",   32'(occupancy_o), 32'd0);
        chk("flush_valid0", 32'(valid_o),     32'd0);
        chk("flush_ready1", 32'(ready_o),     32'd1);
        step();
        chk("flush_no_ghost_valid", 32'(valid_o), 32'd0);
        chk("flush_data_hold",      data_o,       32'h11);

        // Asynchronous reset with two entries held, checked between edges.
        ready_i = 1'b0; mode_i = 2'b01;
        valid_i = 1'b1; imm_i = 16'h0AAA; step();
        imm_i = 16'h0BBB; step();
        valid_i = 1'b0;
        chk("arst_pre_occ", 32'(occupancy_o), 32'd2);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_occ",   32'(occupancy_o), 32'd0);
        chk("arst_valid", 32'(valid_o),     32'd0);
        chk("arst_ready", 32'(ready_o),     32'd1);
        chk("arst_data",  data_o,           32'd0);
        step();
        rst_i = 1'b1; ready_i = 1'b1;
        step();
        chk("arst_after_occ", 32'(occupancy_o), 32'd0);

        // Narrow instance: IN_W=12, OUT_W=24.
        foreach (vecs12[i]) begin
            v12_valid_i = 1'b1; v12_imm_i = vecs12[i].imm; v12_mode_i = vecs12[i].mode;
            step();
            chk($sformatf("w12_vec%0d_data", i), 32'(v12_data_o), 32'(vecs12[i].exp));
            chk($sformatf("w12_vec%0d_occ", i), 32'(v12_occ_o), 32'd1);
        end
        v12_valid_i = 1'b0;
        step();
        chk("w12_drain",  32'(v12_valid_o), 32'd0);
        chk("w12_ready",  32'(v12_ready_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
